// File: rtl/dio_interlock_seq.sv
// Interlock sequencer: synchronises and debounces interlock inputs, forces the safe DO
// pattern on a fault and sequences TRIP/HOLD/ARMED. Define DIO_IL_AUTO_CLEAR_EN to leave ARMED without i_clear.
module dio_interlock_seq #(
  parameter int N_IL   = 8,
  parameter int DEB_W  = 16,
  parameter int HOLD_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_areset,
  input  logic [N_IL-1:0]   i_interlock,
  input  logic [N_IL-1:0]   i_il_mask,
  input  logic [DEB_W-1:0]  i_deb_len,
  input  logic [HOLD_W-1:0] i_hold_len,
  input  logic              i_clear,
  input  logic [N_IL-1:0]   i_axi_do,
  input  logic [N_IL-1:0]   i_interlock_do_en,
  output logic [N_IL-1:0]   o_do,
  output logic [1:0]        o_state,
  output logic              o_trip,
  output logic [N_IL-1:0]   o_trip_src,
  output logic [CNT_W-1:0]  o_trip_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIP  = 2'd1,
    HOLD  = 2'd2,
    ARMED = 2'd3
  } state_t;

  logic [N_IL-1:0]   sync1;
  logic [N_IL-1:0]   sy;
  logic [N_IL-1:0]   filt;
  logic [DEB_W-1:0]  deb_cnt [N_IL];
  logic [N_IL-1:0]   active;
  logic              any_active;

  state_t            state;
  state_t            state_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nx;
  logic [N_IL-1:0]   src_nx;
  logic              count_trip;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      sync1 <= '0;
      sy    <= '0;
    end else begin
      sync1 <= i_interlock;
      sy    <= sync1;
    end
  end

  // Deassertion is immediate; assertion needs i_deb_len+1 consecutive high samples of sy.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      filt <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int i = 0; i < N_IL; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IL; i++) begin
        if (!sy[i]) begin
          deb_cnt[i] <= '0;
          filt[i]    <= 1'b0;
        end else begin
          if (deb_cnt[i] != '1) deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          filt[i] <= (deb_cnt[i] >= i_deb_len);
        end
      end
    end
  end

  assign active     = filt & ~i_il_mask;
  assign any_active = |active;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    src_nx      = o_trip_src;
    count_trip  = 1'b0;
`ifdef DIO_IL_AUTO_CLEAR_EN
    if (i_clear) src_nx = '0;
`endif
    case (state)
      IDLE: begin
        if (any_active) begin
          state_nx   = TRIP;
          src_nx     = active;
          count_trip = 1'b1;
        end
      end
      TRIP: begin
        if (!any_active) begin
          state_nx    = HOLD;
          hold_cnt_nx = '0;
        end
      end
      HOLD: begin
        if (any_active) begin
          state_nx = TRIP;
        end else begin
          hold_cnt_nx = hold_cnt + HOLD_W'(1);
          if (hold_cnt == i_hold_len) state_nx = ARMED;
        end
      end
      ARMED: begin
        if (any_active) begin
          state_nx   = TRIP;
          count_trip = 1'b1;
`ifdef DIO_IL_AUTO_CLEAR_EN
        end else begin
          state_nx = IDLE;
        end
`else
        end else if (i_clear) begin
          state_nx = IDLE;
          src_nx   = '0;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so o_do switches on the same edge as o_state.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      o_do       <= '0;
      o_trip     <= 1'b0;
      o_trip_src <= '0;
      o_trip_cnt <= '0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_cnt_nx;
      o_do       <= (state_nx != IDLE) ? i_interlock_do_en : i_axi_do;
      o_trip     <= (state_nx != IDLE);
      o_trip_src <= src_nx;
      if (count_trip && (o_trip_cnt != '1)) o_trip_cnt <= o_trip_cnt + CNT_W'(1);
    end
  end

  assign o_state = state;

endmodule
